block_drawer: RTL

- Downstream of the block-placement stage. Takes the four 16-bit block descriptors it produces and rasterises them into the 160x120 VGA frame buffer.
- The frame buffer is driven through the standard x/y/colour/plot write port, one pixel per clock.
- On each draw request the block clears the screen to the background colour, then draws every enabled block as a filled rectangle in its own colour.

---
 rtl/block_pkg.sv | 48 ++++
 rtl/xy_scan_counter.sv | 54 +++++
 rtl/block_drawer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/block_pkg.sv
// Shared constants, state encoding and helpers for the block rasteriser.
// Descriptor layout: [0] orientation, [8:1] x origin, [15:9] y origin.
package block_pkg;

  localparam int ORIENT_BIT = 0;
  localparam int X_LSB      = 1;
  localparam int X_MSB      = 8;
  localparam int Y_LSB      = 9;
  localparam int Y_MSB      = 15;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BLOCK_LEN = 12;
  localparam int BLOCK_WID = 4;

  localparam logic HORZ = 1'b0;
  localparam logic VERT = 1'b1;

  localparam logic [2:0] BG_COLOUR = 3'b000;
  localparam logic [2:0] COLOUR1   = 3'b100;
  localparam logic [2:0] COLOUR2   = 3'b010;
  localparam logic [2:0] COLOUR3   = 3'b001;
  localparam logic [2:0] COLOUR4   = 3'b110;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  // Lowest enabled block index >= from; bit [2] flags that one exists.
  function automatic logic [2:0] next_enabled(input logic [3:0] en, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] block_colour(input logic [1:0] idx);
    logic [2:0] c;
    case (idx)
      2'd0:    c = COLOUR1;
      2'd1:    c = COLOUR2;
      2'd2:    c = COLOUR3;
      default: c = COLOUR4;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Raster-order 2-D counter (x inner, y outer) with runtime limits.
// clr_i returns to (0,0) and wins over adv_i; last_o marks the final position.
module xy_scan_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [XW-1:0] width_i,
  input  logic [YW-1:0] height_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end  = (x_q == width_i - XW'(1));
  assign y_end  = (y_q == height_i - YW'(1));
  assign last_o = x_end && y_end;
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/block_drawer.sv
// Clears the 160x120 frame buffer then paints each enabled block as a filled
// rectangle, one registered pixel write per clock.
module block_drawer
  import block_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] block1,
  input  logic [15:0] block2,
  input  logic [15:0] block3,
  input  logic [15:0] block4,
  input  logic [3:0]  block_en,
  input  logic        start,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  state_t      state_q;
  logic [15:0] snap_q [4];
  logic [3:0]  snap_en_q;
  logic [1:0]  blk_idx_q;

  logic [7:0]  vga_x_q;
  logic [6:0]  vga_y_q;
  logic [2:0]  vga_colour_q;
  logic        vga_plot_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  logic        scan_last;
  logic        scan_clr;
  logic        scan_adv;
  logic [7:0]  width_d;
  logic [6:0]  height_d;

  logic [15:0] cur_blk;
  logic [8:0]  sum_x_d;
  logic [7:0]  sum_y_d;
  logic        in_bounds_d;
  logic [2:0]  nxt_blk_d;

  // The scan counter idles at (0,0) and is re-zeroed whenever a scan finishes,
  // so every CLEAR or DRAW pass starts from its own origin.
  assign scan_clr = ((state_q != CLEAR) && (state_q != DRAW)) || scan_last;
  assign scan_adv = !scan_clr;

  always_comb begin
    cur_blk = snap_q[blk_idx_q];
    if (state_q == CLEAR) begin
      width_d  = 8'(SCREEN_W);
      height_d = 7'(SCREEN_H);
    end else if (cur_blk[ORIENT_BIT] == VERT) begin
      width_d  = 8'(BLOCK_WID);
      height_d = 7'(BLOCK_LEN);
    end else begin
      width_d  = 8'(BLOCK_LEN);
      height_d = 7'(BLOCK_WID);
    end
    sum_x_d     = {1'b0, cur_blk[X_MSB:X_LSB]} + {1'b0, scan_x};
    sum_y_d     = {1'b0, cur_blk[Y_MSB:Y_LSB]} + {1'b0, scan_y};
    in_bounds_d = (sum_x_d < 9'(SCREEN_W)) && (sum_y_d < 8'(SCREEN_H));
    nxt_blk_d   = next_enabled(snap_en_q, (state_q == DRAW) ? ({1'b0, blk_idx_q} + 3'd1) : 3'd0);
  end

  xy_scan_counter #(.XW(8), .YW(7)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (scan_clr),
    .adv_i    (scan_adv),
    .width_i  (width_d),
    .height_i (height_d),
    .x_o      (scan_x),
    .y_o      (scan_y),
    .last_o   (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_en_q    <= '0;
      blk_idx_q    <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          vga_plot_q <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            snap_q[0] <= block1;
            snap_q[1] <= block2;
            snap_q[2] <= block3;
            snap_q[3] <= block4;
            snap_en_q <= block_en;
            blk_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          vga_x_q      <= scan_x;
          vga_y_q      <= scan_y;
          vga_colour_q <= BG_COLOUR;
          vga_plot_q   <= 1'b1;
          if (scan_last) begin
            blk_idx_q <= nxt_blk_d[1:0];
            state_q   <= nxt_blk_d[2] ? DRAW : DONE;
          end
        end
        DRAW: begin
          // Off-screen pixels still take their slot, just without a write.
          vga_x_q      <= sum_x_d[7:0];
          vga_y_q      <= sum_y_d[6:0];
          vga_colour_q <= block_colour(blk_idx_q);
          vga_plot_q   <= in_bounds_d;
          if (scan_last) begin
            blk_idx_q <= nxt_blk_d[1:0];
            state_q   <= nxt_blk_d[2] ? DRAW : DONE;
          end
        end
        DONE: begin
          vga_plot_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
